// File: rtl/uart_frame_tx_if.sv
// Handshake bundle for uart_frame_tx: host control, FIFO read port and serial line.
// master = host/FIFO side, slave = the transmitter.
interface uart_frame_tx_if;
  logic       start;
  logic       abort;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       txd;
  logic       busy;
  logic       done;

  modport master (output start, abort, rd_data, input rd_req, txd, busy, done);
  modport slave  (input start, abort, rd_data, output rd_req, txd, busy, done);
endinterface

// File: rtl/uart_frame_tx.sv
// 8N1 frame transmitter: sync header, NUM_BYTES pixels prefetched from a FIFO, back-to-back.
// Define UART_FRAME_CSUM_EN to append an XOR checksum byte of the pixels before finishing.
module uart_frame_tx #(
  parameter int         CLK_DIV   = 1302,
  parameter int         NUM_BYTES = 307200,
  parameter int         CNT_W     = 19,
  parameter logic [7:0] SYNC0     = 8'hA5,
  parameter logic [7:0] SYNC1     = 8'h5A
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_tx_if.slave  bus
);

  localparam int              CYC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_DIV - 1);
  localparam logic [CYC_W-1:0] CYC_PRE  = CYC_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PIX,
`ifdef UART_FRAME_CSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       bit_q, bit_d;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic             abort_q, abort_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic abort_now, bit_end, byte_end, last_pix, next_is_pix;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    data_d     = data_q;
    pix_d      = pix_q;
    abort_d    = abort_q;
`ifdef UART_FRAME_CSUM_EN
    csum_d     = csum_q;
`endif
    bus.rd_req = 1'b0;
    bus.txd    = 1'b1;
    bus.busy   = (state_q != S_IDLE) && (state_q != S_FIN);
    bus.done   = (state_q == S_FIN);

    abort_now   = abort_q | bus.abort;
    bit_end     = (cyc_q == CYC_LAST);
    byte_end    = bit_end && (bit_q == 4'd9);
    last_pix    = (pix_q == PIX_LAST);
    next_is_pix = (state_q == S_HDR1) || ((state_q == S_PIX) && !last_pix);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_HDR0;
          cyc_d   = '0;
          bit_d   = 4'd0;
          data_d  = SYNC0;
          pix_d   = '0;
          abort_d = 1'b0;
`ifdef UART_FRAME_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (bit_q == 4'd0)      bus.txd = 1'b0;
        else if (bit_q != 4'd9) bus.txd = data_q[0];
        abort_d = abort_now;

        // Fetch one cycle early so the pixel lands in the shift register on the final stop cycle.
        if ((bit_q == 4'd9) && (cyc_q == CYC_PRE) && next_is_pix && !abort_q)
          bus.rd_req = 1'b1;

        if (bit_end) begin
          cyc_d = '0;
          bit_d = bit_q + 4'd1;
          if ((bit_q != 4'd0) && (bit_q != 4'd9)) data_d = data_q >> 1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end

        if (byte_end) begin
          bit_d = 4'd0;
          if (abort_now) begin
            state_d = S_IDLE;
          end else begin
            case (state_q)
              S_HDR0: begin
                state_d = S_HDR1;
                data_d  = SYNC1;
              end
              S_HDR1: begin
                state_d = S_PIX;
                data_d  = bus.rd_data;
`ifdef UART_FRAME_CSUM_EN
                csum_d  = csum_q ^ bus.rd_data;
`endif
              end
              S_PIX: begin
                if (last_pix) begin
`ifdef UART_FRAME_CSUM_EN
                  state_d = S_CSUM;
                  data_d  = csum_q;
`else
                  state_d = S_FIN;
`endif
                end else begin
                  pix_d  = pix_q + 1'b1;
                  data_d = bus.rd_data;
`ifdef UART_FRAME_CSUM_EN
                  csum_d = csum_q ^ bus.rd_data;
`endif
                end
              end
`ifdef UART_FRAME_CSUM_EN
              S_CSUM: state_d = S_FIN;
`endif
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= 4'd0;
      data_q  <= 8'h00;
      pix_q   <= '0;
      abort_q <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      abort_q <= abort_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with CLK_DIV=4, NUM_BYTES=3 and a FIFO returning 11, 22, 83.
module tb_uart_frame_tx;

  localparam int BITC = 4;
  localparam int BYTC = 10 * BITC;
`ifdef UART_FRAME_CSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int MAXC = 300;

  logic clk = 1'b0;
  logic rst;
  logic fifo_clr = 1'b0;
  int   fifo_idx = 0;
  int   passed = 0;
  int   total  = 0;

  logic       txd_a  [0:MAXC];
  logic       busy_a [0:MAXC];
  logic       done_a [0:MAXC];
  logic       rdq_a  [0:MAXC];
  logic [7:0] exp_bytes [0:5];
  int         c_done;

  uart_frame_tx_if bus ();

  uart_frame_tx #(.CLK_DIV(4), .NUM_BYTES(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame FIFO model: data valid the cycle after rd_req, cycling 11, 22, 83.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_idx <= 0;
    end else if (bus.rd_req) begin
      case (fifo_idx)
        0:       bus.rd_data <= 8'h11;
        1:       bus.rd_data <= 8'h22;
        default: bus.rd_data <= 8'h83;
      endcase
      fifo_idx <= (fifo_idx == 2) ? 0 : fifo_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic exp_txd(input int c);
    int b, k;
    logic [7:0] v;
    b = (c - 1) / BYTC;
    k = ((c - 1) % BYTC) / BITC;
    v = exp_bytes[b];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return v[k-1];
  endfunction

  task automatic clear_fifo();
    @(negedge clk); fifo_clr = 1'b1;
    @(negedge clk); fifo_clr = 1'b0;
  endtask

  // Pulse start in cycle 0, then record outputs for cycles 1..max_c (or until done).
  task automatic run_frame(input int max_c, input int abort_at, input int busy_start_at,
                           input bit fin_start);
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b0;
    c_done = -1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      txd_a[c] = bus.txd; busy_a[c] = bus.busy; done_a[c] = bus.done; rdq_a[c] = bus.rd_req;
      if (c == abort_at) bus.abort = 1'b1;
      if (c == busy_start_at) bus.start = 1'b1;
      if (bus.done) begin
        c_done = c;
        if (fin_start) bus.start = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_line(input string tag, input int nbytes);
    int bad;
    logic [7:0] v;
    bad = 0;
    for (int c = 1; c <= nbytes * BYTC; c++) if (txd_a[c] !== exp_txd(c)) bad++;
    check({tag, "_txd_bad_cycles"}, bad, 0);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 8; i++) v[i] = txd_a[1 + b*BYTC + BITC*(1+i) + 1];
      check($sformatf("%s_byte%0d", tag, b), v, exp_bytes[b]);
    end
  endtask

  task automatic check_rdreq(input string tag, input int last_c, input int n_exp);
    int n;
    int pos [0:3];
    n = 0;
    for (int c = 1; c <= last_c; c++) if (rdq_a[c] === 1'b1) begin
      if (n < 4) pos[n] = c;
      n++;
    end
    check({tag, "_rdreq_count"}, n, n_exp);
    for (int i = 0; i < n_exp && i < n; i++)
      check($sformatf("%s_rdreq%0d_cycle", tag, i), pos[i], 39 + BYTC*(i+1));
  endtask

  task automatic check_normal(input string tag);
    int lows;
    lows = 0;
    check({tag, "_done_cycle"}, c_done, NB*BYTC + 1);
    if (c_done > 0) begin
      for (int c = 1; c < c_done; c++) if (busy_a[c] !== 1'b1 || done_a[c] !== 1'b0) lows++;
      check({tag, "_busy_during"}, lows, 0);
      check({tag, "_fin_busy"}, busy_a[c_done], 1'b0);
      check({tag, "_fin_txd"}, txd_a[c_done], 1'b1);
      check_line(tag, NB);
      check_rdreq(tag, c_done, 3);
    end
  endtask

  initial begin
    int hi;
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h5A; exp_bytes[2] = 8'h11;
    exp_bytes[3] = 8'h22; exp_bytes[4] = 8'h83; exp_bytes[5] = 8'hB0;
    bus.rd_data = 8'h00;

    // Reset held 3 cycles with start asserted throughout.
    rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_txd", i), bus.txd, 1'b1);
      check($sformatf("rst%0d_busy", i), bus.busy, 1'b0);
      check($sformatf("rst%0d_done", i), bus.done, 1'b0);
      check($sformatf("rst%0d_rdreq", i), bus.rd_req, 1'b0);
    end
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_txd", bus.txd, 1'b1);

    // Normal frame.
    run_frame(MAXC - 10, -1, -1, 1'b0);
    check_normal("frame");

    // Abort during data bit 3 of the second pixel.
    clear_fifo();
    run_frame(200, 1 + 3*BYTC + 4*BITC, -1, 1'b0);
    check("abort_no_done", c_done, -1);
    check("abort_busy_last", busy_a[4*BYTC], 1'b1);
    check("abort_busy_after", busy_a[4*BYTC + 1], 1'b0);
    check_line("abort", 4);
    check_rdreq("abort", 200, 2);
    hi = 0;
    for (int c = 4*BYTC + 1; c <= 200; c++) if (txd_a[c] === 1'b1 && busy_a[c] === 1'b0) hi++;
    check("abort_idle_cycles", hi, 200 - 4*BYTC);

    // Starts while busy and in FIN ignored; start right after FIN gives an identical frame.
    clear_fifo();
    run_frame(MAXC - 10, -1, 50, 1'b1);
    check_normal("busy_start");
    run_frame(MAXC - 10, -1, -1, 1'b0);
    check_normal("restart");

    // Reset in the middle of the first pixel's start bit.
    @(negedge clk); bus.start = 1'b1;
    for (int c = 1; c <= 2*BYTC + 2; c++) begin
      @(negedge clk); bus.start = 1'b0;
      if (c == 2*BYTC + 2) begin
        check("midrst_pre_txd", bus.txd, 1'b0);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check("midrst_txd", bus.txd, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    rst = 1'b0;
    clear_fifo();
    run_frame(MAXC - 10, -1, -1, 1'b0);
    check_normal("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
